brush_painter: RTL

- Upstream write-side stage of the per-colour frame buffers.
- On a paint request it captures the current ball origin and a brush colour. It then walks the ball footprint one pixel per VGA_CLK, driving write-enable, coordinates and RGB into the red/green/blue buffers.
- Lets the ball leave a persistent trail. Sits between the ball-position/button logic and the buffer write port; the zera_buffer clear path is muxed in front of it by the top level.

---
 rtl/brush_painter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/brush_painter.sv
// Brush painter: on request, captures ball origin and brush colour, then walks the
// (SIZE+1)x(SIZE+1) footprint one pixel per clock into the frame-buffer write port.
//
// state | meaning
// IDLE  | waiting for paint_req; origin and colour latched on accept
// PAINT | issuing one footprint pixel per cycle in raster order, off-screen pixels clipped
// DONE  | single-cycle completion pulse, then back to IDLE
module brush_painter #(
    parameter int SIZE    = 16,
    parameter int W_RES   = 640,
    parameter int H_RES   = 480,
    parameter int COORD_W = 11
) (
    input  logic               VGA_CLK,
    input  logic               reset,
    input  logic               paint_req,
    input  logic [COORD_W-1:0] ball_x,
    input  logic [COORD_W-1:0] ball_y,
    input  logic [7:0]         brush_r,
    input  logic [7:0]         brush_g,
    input  logic [7:0]         brush_b,
    output logic               busy,
    output logic               wr_en,
    output logic [COORD_W-1:0] wr_x,
    output logic [COORD_W-1:0] wr_y,
    output logic [7:0]         wr_r,
    output logic [7:0]         wr_g,
    output logic [7:0]         wr_b,
    output logic               done
);

    typedef enum logic [1:0] {IDLE, PAINT, DONE} state_t;

    localparam logic [6:0]       LAST  = 7'(SIZE);
    localparam logic [COORD_W:0] X_LIM = (COORD_W+1)'(W_RES);
    localparam logic [COORD_W:0] Y_LIM = (COORD_W+1)'(H_RES);

    state_t             state, state_n;
    logic [COORD_W-1:0] ox, oy, ox_n, oy_n;
    logic [7:0]         cr, cg, cb, cr_n, cg_n, cb_n;
    logic [6:0]         dx, dy, dx_n, dy_n;
    logic               busy_n, wr_en_n, done_n;
    logic [COORD_W-1:0] wr_x_n, wr_y_n;
    logic [7:0]         wr_r_n, wr_g_n, wr_b_n;
    logic [COORD_W:0]   px, py;

    // One extra bit so an origin near the top of the coordinate range cannot wrap into view.
    assign px = {1'b0, ox} + {{(COORD_W-6){1'b0}}, dx};
    assign py = {1'b0, oy} + {{(COORD_W-6){1'b0}}, dy};

    always_ff @(posedge VGA_CLK) begin
        if (!reset) begin
            state <= IDLE;
            ox    <= '0;
            oy    <= '0;
            cr    <= '0;
            cg    <= '0;
            cb    <= '0;
            dx    <= '0;
            dy    <= '0;
            busy  <= 1'b0;
            wr_en <= 1'b0;
            done  <= 1'b0;
            wr_x  <= '0;
            wr_y  <= '0;
            wr_r  <= '0;
            wr_g  <= '0;
            wr_b  <= '0;
        end else begin
            state <= state_n;
            ox    <= ox_n;
            oy    <= oy_n;
            cr    <= cr_n;
            cg    <= cg_n;
            cb    <= cb_n;
            dx    <= dx_n;
            dy    <= dy_n;
            busy  <= busy_n;
            wr_en <= wr_en_n;
            done  <= done_n;
            wr_x  <= wr_x_n;
            wr_y  <= wr_y_n;
            wr_r  <= wr_r_n;
            wr_g  <= wr_g_n;
            wr_b  <= wr_b_n;
        end
    end

    always_comb begin
        state_n = state;
        ox_n    = ox;
        oy_n    = oy;
        cr_n    = cr;
        cg_n    = cg;
        cb_n    = cb;
        dx_n    = dx;
        dy_n    = dy;
        busy_n  = busy;
        wr_en_n = 1'b0;
        done_n  = 1'b0;
        wr_x_n  = wr_x;
        wr_y_n  = wr_y;
        wr_r_n  = wr_r;
        wr_g_n  = wr_g;
        wr_b_n  = wr_b;
        case (state)
            IDLE: begin
                busy_n = 1'b0;
                if (paint_req) begin
                    ox_n    = ball_x;
                    oy_n    = ball_y;
                    cr_n    = brush_r;
                    cg_n    = brush_g;
                    cb_n    = brush_b;
                    dx_n    = '0;
                    dy_n    = '0;
                    busy_n  = 1'b1;
                    state_n = PAINT;
                end
            end
            PAINT: begin
                wr_x_n  = px[COORD_W-1:0];
                wr_y_n  = py[COORD_W-1:0];
                wr_r_n  = cr;
                wr_g_n  = cg;
                wr_b_n  = cb;
                wr_en_n = (px < X_LIM) && (py < Y_LIM);
                if (dx == LAST) begin
                    dx_n = '0;
                    if (dy == LAST) begin
                        dy_n    = '0;
                        state_n = DONE;
                    end else begin
                        dy_n = dy + 7'd1;
                    end
                end else begin
                    dx_n = dx + 7'd1;
                end
            end
            DONE: begin
                done_n  = 1'b1;
                busy_n  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
